mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, log2 of memory depth in 32-bit words (256 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  1  access request from the CPU, sampled only in IDLE.
REQ-006 SHALL have port memwrite  input  1  1 = store, 0 = load; qualified by req.
REQ-007 SHALL have port addr  input  32  byte address (CPU aluout).
REQ-008 SHALL have port writedata  input  32  store data.
REQ-009 SHALL have port readdata  output  32  load data, registered; valid while ready=1.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port addr_err  output  1  misaligned-access flag, valid while ready=1.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-013 IDLE with req=1 SHALL latch addr, writedata and memwrite on the clock edge; req=0 keeps IDLE.
REQ-014 From IDLE on accepted req: addr[1:0]!=0 -> DONE with addr_err=1, no memory update; else WAIT_CYCLES>0 -> WAIT with counter=WAIT_CYCLES; else -> DONE.
REQ-015 WAIT SHALL decrement the counter each cycle and go to DONE on the edge where the counter equals 1.
REQ-016 A latched aligned store SHALL write the RAM on the edge entering DONE; a load SHALL register RAM data into readdata on the same edge.
REQ-017 Store completion SHALL drive readdata = stored writedata (write-through echo).
REQ-018 DONE SHALL last exactly one cycle with ready=1, then return to IDLE; back-to-back: req may be accepted in the IDLE cycle immediately following.
REQ-019 Latency from accepting edge to ready high SHALL be WAIT_CYCLES+1 cycles (1 cycle when misaligned).
REQ-020 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits ignored (wrap-around aliasing).
REQ-021 req, addr, writedata, memwrite changes during WAIT/DONE SHALL be ignored; no request queued.
REQ-022 readdata and addr_err SHALL hold their last values outside DONE; ready=0 outside DONE.
REQ-023 Misaligned access SHALL return readdata=0 and addr_err=1 in its DONE cycle.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, counter 0, ready 0, addr_err 0, readdata 0.
REQ-025 RAM contents SHALL not be reset.
REQ-026 Reset asserted in WAIT SHALL abort the access; the pending store SHALL never be written.
REQ-027 First request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro MEM_RESPONDER_WAIT_STATE_EN defined: WAIT state and counter present, WAIT_CYCLES honoured per REQ-014/015.
REQ-029 Macro MEM_RESPONDER_WAIT_STATE_EN undefined: no WAIT state or counter, WAIT_CYCLES ignored, every access IDLE->DONE with 1-cycle latency.

Verification
REQ-030 Store addr=0x10, data=0xDEADBEEF, WAIT_CYCLES=2 -> ready high exactly 3 cycles after accept, readdata=0xDEADBEEF, addr_err=0.
REQ-031 Load addr=0x10 after REQ-030 store -> readdata=0xDEADBEEF at ready; load addr=0x410 (DEPTH_LOG2=8) -> same data (wrap).
REQ-032 Store addr=0x22 -> ready after 1 cycle, addr_err=1, readdata=0; subsequent load addr=0x20 returns prior contents unchanged.
REQ-033 Store to 0x30 with rst pulsed during WAIT -> ready never asserts, outputs 0, later load of 0x30 returns old contents.
REQ-034 req held high continuously -> ready pulses every WAIT_CYCLES+2 cycles, one access per pulse; req toggled during WAIT has no effect.
REQ-035 Macro undefined, WAIT_CYCLES=5 -> every access completes with ready 1 cycle after accept.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word RAM behind a req/ready handshake with optional wait states and misalignment detection.
// Define MEM_RESPONDER_WAIT_STATE_EN to enable the WAIT state and its WAIT_CYCLES countdown.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef MEM_RESPONDER_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    acc_we;
  logic                    finish;
  logic                    mem_we;

  // Upper address bits alias onto the same words by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
    cnt_d     = cnt_q;
`endif
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    finish    = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d     = addr[DEPTH_LOG2+1:2];
          wdata_d   = writedata;
          we_d      = memwrite;
          // A zero-wait access completes on the accepting edge, so use the live inputs.
          acc_idx   = addr[DEPTH_LOG2+1:2];
          acc_wdata = writedata;
          acc_we    = memwrite;
          if (addr[1:0] != 2'b00) begin
            state_d = DONE;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
`ifdef MEM_RESPONDER_WAIT_STATE_EN
            if (WAIT_CYCLES > 0) begin
              state_d = WAIT;
              cnt_d   = WAIT_INIT;
            end else begin
              finish  = 1'b1;
            end
`else
            finish = 1'b1;
`endif
          end
        end
      end
`ifdef MEM_RESPONDER_WAIT_STATE_EN
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          finish = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      state_d = DONE;
      err_d   = 1'b0;
      mem_we  = acc_we && !rst;
      rdata_d = acc_we ? acc_wdata : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
      cnt_q   <= 4'd0;
`endif
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef MEM_RESPONDER_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Latched request fields and RAM contents carry no reset.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    we_q    <= we_d;
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign readdata = rdata_q;
  assign addr_err = err_q;
  assign ready    = (state_q == DONE);

endmodule
